// File: rtl/demux32_buf_pkg.sv
// ---------------------------------------------------------------------------
// demux32_buf_pkg
// Package shared with the processor's register-file path. It holds the
// default data width, the width of the delivery counters, and the meaning
// of the route-select bit.
// ---------------------------------------------------------------------------
package demux32_buf_pkg;

   localparam int DATA_W = 32;   // default data path width
   localparam int CNT_W  = 16;   // width of the per-output delivery counters

   // Destination encoding of in_sel
   typedef enum logic {
      SEL_OUT1 = 1'b0,
      SEL_OUT2 = 1'b1
   } sel_e;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage : demux32_buf_pkg

// File: rtl/demux32_buf_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy. A push is refused when the
// FIFO is full, even if a pop happens in the same cycle, so there is never a
// same-cycle pass-through into a freed slot. A pop is ignored when empty.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset (pointers and occupancy only)
//   i_push   : write i_data this cycle (ignored when full)
//   i_data   : word to write
//   i_pop    : remove the oldest entry this cycle (ignored when empty)
//   o_data   : oldest entry (don't-care while empty)
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
//   o_count  : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
   import demux32_buf_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2,                 // power of two, >= 2
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [OCC_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_count == OCC_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];

   // Fullness is judged on the registered occupancy, before any same-cycle pop.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop  && !o_empty;

   // NOTE: storage has no reset; its contents are only observed through
   // o_data while occupancy is non-zero, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leaves the occupancy unchanged.
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule : sync_fifo

// File: rtl/demux32_buf.sv
// ---------------------------------------------------------------------------
// demux32_buf
// Routes a valid/ready input stream to one of two buffered output streams.
// Each output owns an independent FIFO, so a stalled output never blocks
// traffic to the other. A free-running counter per output counts delivered
// words (wrapping at 16 bits).
//
// Ports
//   clk, rst_n            : clock and synchronous active-low reset
//   in_valid/in_ready     : input handshake; in_ready depends only on in_sel
//                           and the selected FIFO's registered fullness
//   in_data               : word to route
//   in_sel                : 0 -> output 1, 1 -> output 2
//   outN_valid/outN_ready : output N handshake (outN_valid = FIFO N not empty)
//   outN_data             : oldest word of FIFO N
//   cnt1, cnt2            : words delivered on outputs 1 and 2
// ---------------------------------------------------------------------------
module demux32_buf
   import demux32_buf_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = 2                  // power of two, >= 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             w_full1, w_full2;
   logic             w_empty1, w_empty2;
   logic             w_accept;
   logic             w_push1, w_push2;
   logic             w_pop1, w_pop2;
   // Occupancy is not needed at this level; the full/empty flags suffice.
   logic [OCC_W-1:0] w_unused_count1, w_unused_count2;

   cnt_t r_cnt1;
   cnt_t r_cnt2;

   // Steering: readiness follows the selected queue only, never in_valid.
   assign in_ready   = (in_sel == SEL_OUT2) ? !w_full2 : !w_full1;
   assign w_accept   = in_valid && in_ready;
   assign w_push1    = w_accept && (in_sel == SEL_OUT1);
   assign w_push2    = w_accept && (in_sel == SEL_OUT2);

   assign out1_valid = !w_empty1;
   assign out2_valid = !w_empty2;
   assign w_pop1     = out1_valid && out1_ready;
   assign w_pop2     = out2_valid && out2_ready;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push1),
      .i_data  (in_data),
      .i_pop   (w_pop1),
      .o_data  (out1_data),
      .o_full  (w_full1),
      .o_empty (w_empty1),
      .o_count (w_unused_count1)
   );

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push2),
      .i_data  (in_data),
      .i_pop   (w_pop2),
      .o_data  (out2_data),
      .o_full  (w_full2),
      .o_empty (w_empty2),
      .o_count (w_unused_count2)
   );

   // Delivery counters wrap naturally at 16 bits; reset has priority, so
   // nothing is counted in a reset cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt1 <= '0;
         r_cnt2 <= '0;
      end else begin
         if (w_pop1) begin
            r_cnt1 <= r_cnt1 + 1'b1;
         end
         if (w_pop2) begin
            r_cnt2 <= r_cnt2 + 1'b1;
         end
      end
   end

   assign cnt1 = r_cnt1;
   assign cnt2 = r_cnt2;

endmodule : demux32_buf
